// File: rtl/voj_pkg.sv
// rtl/voj_pkg.sv - shared state type and default window for the mismatch checker
package voj_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } chk_state_t;

    localparam int VOJ_DEFAULT_WINDOW = 40;

endpackage

// File: rtl/mismatch_checker_sat_counter.sv
// rtl/mismatch_checker_sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int W   = 6,
    parameter int MAX = 40
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    // Clear wins over increment so a restart never carries a stale count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != MAX_V)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/mismatch_checker.sv
// rtl/mismatch_checker.sv - windowed DUT-vs-reference scoring stage; optional MISMATCH_CHECKER_EARLY_STOP_EN
module mismatch_checker
    import voj_pkg::*;
#(
    parameter  int WIDTH  = 1,
    parameter  int WINDOW = VOJ_DEFAULT_WINDOW,
    localparam int CNT_W  = $clog2(WINDOW + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             ack,
    input  logic [WIDTH-1:0] dut_y,
    input  logic [WIDTH-1:0] ref_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic             first_err_vld,
    output logic [CNT_W-1:0] first_err_idx
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WINDOW - 1);

    chk_state_t       state;
    chk_state_t       state_next;
    logic             mis;
    logic             clr;
    logic             run;
    logic             last;
    logic             stop;
    logic [CNT_W-1:0] idx;

    // Case inequality so that unknown values on either side score as a failure.
    assign mis  = (dut_y !== ref_y);
    assign run  = (state == RUN);
    assign last = (idx == LAST_IDX);

`ifdef MISMATCH_CHECKER_EARLY_STOP_EN
    assign stop = last || mis;
`else
    assign stop = last;
`endif

    always_comb begin
        state_next = state;
        clr        = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    clr        = 1'b1;
                end
            end
            RUN: begin
                if (stop) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (ack) begin
                    if (start) begin
                        state_next = RUN;
                        clr        = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    sat_counter #(
        .W   (CNT_W),
        .MAX (WINDOW - 1)
    ) u_idx_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (run),
        .cnt   (idx)
    );

    sat_counter #(
        .W   (CNT_W),
        .MAX (WINDOW)
    ) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (run && mis),
        .cnt   (err_cnt)
    );

    // busy/done are registered copies of the next state so no input reaches an output combinationally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            first_err_vld <= 1'b0;
            first_err_idx <= '0;
        end else begin
            state <= state_next;
            busy  <= (state_next == RUN);
            done  <= (state_next == DONE);
            if (clr) begin
                pass          <= 1'b0;
                first_err_vld <= 1'b0;
                first_err_idx <= '0;
            end else if (run) begin
                if (mis && !first_err_vld) begin
                    first_err_vld <= 1'b1;
                    first_err_idx <= idx;
                end
                if (state_next == DONE) begin
                    pass <= (err_cnt == '0) && !mis;
                end
            end
        end
    end

endmodule

// File: tb/tb_mismatch_checker.sv
// tb/tb_mismatch_checker.sv - scoreboard bench for mismatch_checker
module tb_mismatch_checker;

    localparam int WIN   = 40;
    localparam int CNT_W = $clog2(WIN + 1);
`ifdef MISMATCH_CHECKER_EARLY_STOP_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef struct {
        logic             pass;
        logic [CNT_W-1:0] cnt;
        logic             vld;
        logic [CNT_W-1:0] fidx;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             ack;
    logic [0:0]       dut_y;
    logic [0:0]       ref_y;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] err_cnt;
    logic             first_err_vld;
    logic [CNT_W-1:0] first_err_idx;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    mismatch_checker #(
        .WIDTH  (1),
        .WINDOW (WIN)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .ack           (ack),
        .dut_y         (dut_y),
        .ref_y         (ref_y),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_cnt       (err_cnt),
        .first_err_vld (first_err_vld),
        .first_err_idx (first_err_idx)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [WIN-1:0] mask);
        exp_t e;
        int   c;
        c      = 0;
        e.vld  = 1'b0;
        e.fidx = '0;
        for (int i = WIN - 1; i >= 0; i--) begin
            if (mask[i]) begin
                c++;
                e.vld  = 1'b1;
                e.fidx = CNT_W'(i);
            end
        end
        if (EARLY && c > 0) c = 1;
        e.cnt  = CNT_W'(c);
        e.pass = (c == 0);
        sb.push_back(e);
    endtask

    // Drives the window samples after the start edge, then scores the verdict against the queue.
    task automatic drive_window(input logic [WIN-1:0] mask, input bit xin, input int mid_k);
        int   lat;
        int   cyc;
        bit   seen;
        exp_t e;
        lat  = WIN;
        cyc  = -1;
        seen = 1'b0;
        if (EARLY) begin
            for (int i = WIN - 1; i >= 0; i--) begin
                if (mask[i] || xin) lat = i + 1;
            end
        end
        for (int k = 0; k < WIN + 5; k++) begin
            ack   = 1'b0;
            start = (k == mid_k);
            ref_y = 1'b1;
            if (xin) dut_y = 1'bx;
            else if (k < WIN && mask[k]) dut_y = 1'b0;
            else dut_y = 1'b1;
            tick();
            if (done === 1'b1) begin
                seen = 1'b1;
                cyc  = k + 1;
                break;
            end
            chk("busy_run", 32'(busy), 32'd1);
        end
        start = 1'b0;
        dut_y = 1'b1;
        chk("done_seen", 32'(seen), 32'd1);
        chk("latency", 32'(cyc), 32'(lat));
        if (sb.size() == 0) begin
            chk("sb_nonempty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk("pass", 32'(pass), 32'(e.pass));
            chk("err_cnt", 32'(err_cnt), 32'(e.cnt));
            chk("first_err_vld", 32'(first_err_vld), 32'(e.vld));
            chk("first_err_idx", 32'(first_err_idx), 32'(e.fidx));
            chk("busy_done", 32'(busy), 32'd0);
        end
    endtask

    task automatic begin_eval(input logic [WIN-1:0] mask);
        push_exp(mask);
        start = 1'b1;
        tick();
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("done_after_ack", 32'(done), 32'd0);
    endtask

    initial begin
        logic [WIN-1:0] m;
        rst_n = 1'b0;
        start = 1'b0;
        ack   = 1'b0;
        dut_y = 1'b0;
        ref_y = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_fvld", 32'(first_err_vld), 32'd0);
        chk("rst_fidx", 32'(first_err_idx), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("idle_busy", 32'(busy), 32'd0);
        end

        // all match, verdict held until ack
        begin_eval('0);
        drive_window('0, 1'b0, -1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_done", 32'(done), 32'd1);
            chk("hold_pass", 32'(pass), 32'd1);
        end
        do_ack();

        // sparse errors at 3, 17, 39
        m = '0;
        m[3] = 1'b1; m[17] = 1'b1; m[39] = 1'b1;
        begin_eval(m);
        drive_window(m, 1'b0, -1);
        do_ack();

        // unknown input for the whole window: saturation boundary
        begin_eval('1);
        drive_window('1, 1'b1, -1);
        chk("x_err_sat", 32'(err_cnt), EARLY ? 32'd1 : 32'(WIN));
        do_ack();

        // start during RUN ignored; ack+start together restarts with cleared counters
        m = '0;
        m[30] = 1'b1;
        begin_eval(m);
        drive_window(m, 1'b0, 10);
        push_exp('0);
        ack   = 1'b1;
        start = 1'b1;
        tick();
        chk("restart_done", 32'(done), 32'd0);
        chk("restart_busy", 32'(busy), 32'd1);
        chk("restart_err_cnt", 32'(err_cnt), 32'd0);
        chk("restart_fvld", 32'(first_err_vld), 32'd0);
        drive_window('0, 1'b0, -1);
        do_ack();

        // reset abort at idx 20
        push_exp('0);
        start = 1'b1;
        tick();
        void'(sb.pop_back());
        for (int k = 0; k < 20; k++) begin
            start = 1'b0;
            ref_y = 1'b1;
            dut_y = (k == 2 && !EARLY) ? 1'b0 : 1'b1;
            tick();
        end
        chk("abort_busy_pre", 32'(busy), 32'd1);
        chk("abort_err_pre", 32'(err_cnt), EARLY ? 32'd0 : 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_err_cnt", 32'(err_cnt), 32'd0);
        chk("abort_fvld", 32'(first_err_vld), 32'd0);
        tick();
        chk("abort_idle", 32'(busy), 32'd0);

        // single mismatch at idx 7 (stops early when the feature is built in)
        m = '0;
        m[7] = 1'b1;
        begin_eval(m);
        drive_window(m, 1'b0, -1);
        do_ack();

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mismatch_checker.md
# mismatch_checker

Sequential checker that sits directly downstream of the judged design and its golden reference. It samples the DUT output `dut_y` against the expected value `ref_y` once per clock over a fixed-length evaluation window. It accumulates a saturating mismatch count and the cycle index of the first failure, then presents a pass/fail verdict held until acknowledged. It replaces free-running combinational `mismatch` flags with a cycle-accurate, synthesizable scoring stage.

## Interface
- `WIDTH`, 1, bit width of compared signals
- `WINDOW`, 40, number of sampled cycles per evaluation (≥1)
- `CNT_W`, `$clog2(WINDOW+1)`, width of counters (derived, not overridden)

- `clk`  in  1  single clock, all logic on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `start`  in  1  begin an evaluation (pulse)
- `ack`  in  1  consumer acknowledges verdict
- `dut_y`  in  WIDTH  DUT output under test
- `ref_y`  in  WIDTH  expected value
- `busy`  out  1  evaluation in progress
- `done`  out  1  verdict valid, held until `ack`
- `pass`  out  1  1 when zero mismatches (valid with `done`)
- `err_cnt`  out  CNT_W  number of mismatching cycles
- `first_err_vld`  out  1  at least one mismatch recorded
- `first_err_idx`  out  CNT_W  window index (0-based) of first mismatch

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: `start`=1 → RUN; clear `err_cnt`, `first_err_*`, `pass`, and the cycle index `idx`.
- RUN: each cycle, compare `dut_y !== ref_y`. X/Z on either input counts as a mismatch. On mismatch, increment `err_cnt`, saturating at `WINDOW`. On the first mismatch, latch `first_err_idx`=`idx` and set `first_err_vld`. `idx` increments each cycle. The sample taken at `idx`=`WINDOW-1` is the last one → DONE.
- DONE: `done`=1, `pass`=(`err_cnt`==0). Outputs are frozen.
  - `ack`=1 → IDLE.
  - `ack` and `start` in the same cycle → RUN directly, with counters cleared.
- `start` during RUN is ignored. `start` in DONE without `ack` is ignored.
- `ack` outside DONE is ignored.

## Timing
- Reset (`rst_n`=0 at a rising edge): state IDLE. `busy`, `done`, `pass`, `first_err_vld` = 0; `err_cnt`, `first_err_idx` = 0. Reset mid-RUN or in DONE aborts with no verdict.
- `start` sampled at edge t → `busy`=1 from t+1. The first comparison happens at edge t+1 (idx 0). The last comparison happens at edge t+WINDOW.
- `done`=1 and `busy`=0 are visible after edge t+WINDOW, i.e. the cycle following the final sample. Latency from `start` to `done` is `WINDOW` cycles.
- `ack` sampled at edge u → `done`=0 after edge u.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `MISMATCH_CHECKER_EARLY_STOP_EN`:
  - Defined: the first mismatch in RUN forces DONE on that same edge. `err_cnt`=1, `pass`=0, `first_err_idx` = that index, and the remaining window is skipped.
  - Undefined: the full `WINDOW` is always sampled, as described above.
- The macro affects only the RUN→DONE transition condition.

## Structure
- Shared package `voj_pkg`:
  - state enum `chk_state_t` {IDLE, RUN, DONE}
  - default `WINDOW` constant `VOJ_DEFAULT_WINDOW`=40
- One sub-module, `sat_counter`: parameterized width and max value, with synchronous clear, increment, and saturation. It is instantiated twice, for `idx` and `err_cnt`.
- Top level contains the FSM and the first-error capture registers.

## Test plan
- Reset then idle: `rst_n`=0 for 2 cycles, with `start`=0 → all outputs 0, `busy`=0 indefinitely.
- All match: WINDOW=40, `dut_y`=`ref_y`=1, `start` at cycle 5 → `done`=1 after cycle 45, `pass`=1, `err_cnt`=0, `first_err_vld`=0, held until `ack`.
- Sparse errors: mismatches at idx 3, 17, 39 → `err_cnt`=3, `first_err_idx`=3, `pass`=0.
- X input: `dut_y`=1'bx for the entire window → `err_cnt`=40 (saturation boundary), `first_err_idx`=0.
- Handshake: `start` during RUN is ignored. `ack`+`start` together in DONE → new RUN with counters cleared, `done` low next cycle.
- Abort and early stop: `rst_n`=0 at idx 20 → IDLE with outputs cleared. With `MISMATCH_CHECKER_EARLY_STOP_EN` defined, a mismatch at idx 7 → `done` after that edge, `err_cnt`=1, `first_err_idx`=7.
